// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divide/remainder unit.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic is_signed_op(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bus between the issue stage (master) and the divider (slave).
// Handshake: a transfer happens on a rising clk edge where valid && ready; the
// sender holds valid and payload stable until that edge, ready may change freely.
interface div_if
  import div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic              req_valid;
    logic              req_ready;
    div_op_e           req_op;
    logic [XLEN-1:0]   req_dividend;
    logic [XLEN-1:0]   req_divisor;
    logic [TAG_W-1:0]  req_tag;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_result;
    logic              resp_divzero;
    logic [TAG_W-1:0]  resp_tag;

    modport master (
        output req_valid, req_op, req_dividend, req_divisor, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_divzero, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_dividend, req_divisor, req_tag, resp_ready,
        output req_ready, resp_valid, resp_result, resp_divzero, resp_tag
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the dividend MSB into the partial
// remainder, subtract the divisor if it fits, and shift the new quotient bit in.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);
    // The shifted remainder needs one extra bit; the difference always fits XLEN.
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign fits    = shifted >= {1'b0, divisor};
    assign diff    = shifted[XLEN-1:0] - divisor;

    always_comb begin
        rem_out = fits ? diff : shifted[XLEN-1:0];
        quo_out = {quo_in[XLEN-2:0], fits};
    end
endmodule

// File: rtl/div_unit.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit: magnitudes are divided with a chain of
// restoring steps, signs are fixed up as the result is registered into DONE.
module div_unit
  import div_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    div_if.slave       bus,
    output logic [1:0] dbg_state
);
    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  rem_q, quo_q, dsr_q;
    logic             neg_q, neg_r, rem_op_q;

    logic             accept, sgn, a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0]  a_mag, b_mag, special_res;
    logic [XLEN-1:0]  q_fin, r_fin;

    assign bus.req_ready  = (state == ST_IDLE) && !flush;
    assign bus.resp_valid = (state == ST_DONE);
    assign dbg_state      = state;
    assign accept         = bus.req_valid && bus.req_ready;

    // Request decode, only meaningful in the accept cycle.
    always_comb begin
        sgn      = is_signed_op(bus.req_op);
        a_neg    = sgn && bus.req_dividend[XLEN-1];
        b_neg    = sgn && bus.req_divisor[XLEN-1];
        a_mag    = a_neg ? -bus.req_dividend : bus.req_dividend;
        b_mag    = b_neg ? -bus.req_divisor  : bus.req_divisor;
        div_zero = (bus.req_divisor == '0);
        ovf      = sgn && (bus.req_dividend == MIN_VAL) && (bus.req_divisor == '1);
        if (div_zero)
            special_res = is_rem_op(bus.req_op) ? bus.req_dividend : '1;
        else
            special_res = is_rem_op(bus.req_op) ? '0 : MIN_VAL;
    end

    logic [XLEN-1:0] rem_chain [BITS_PER_CYCLE+1];
    logic [XLEN-1:0] quo_chain [BITS_PER_CYCLE+1];

    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem_in  (rem_chain[i]),
            .quo_in  (quo_chain[i]),
            .divisor (dsr_q),
            .rem_out (rem_chain[i+1]),
            .quo_out (quo_chain[i+1])
        );
    end

    // Negating a zero remainder yields zero, so no separate zero guard is needed.
    assign q_fin = neg_q ? -quo_chain[BITS_PER_CYCLE] : quo_chain[BITS_PER_CYCLE];
    assign r_fin = neg_r ? -rem_chain[BITS_PER_CYCLE] : rem_chain[BITS_PER_CYCLE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            count            <= '0;
            rem_q            <= '0;
            quo_q            <= '0;
            dsr_q            <= '0;
            neg_q            <= 1'b0;
            neg_r            <= 1'b0;
            rem_op_q         <= 1'b0;
            bus.resp_result  <= '0;
            bus.resp_divzero <= 1'b0;
            bus.resp_tag     <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    rem_op_q     <= is_rem_op(bus.req_op);
                    bus.resp_tag <= bus.req_tag;
                    count        <= '0;
                    if (div_zero || ovf) begin
                        state            <= ST_DONE;
                        bus.resp_result  <= special_res;
                        bus.resp_divzero <= div_zero;
                    end else begin
                        state            <= ST_CALC;
                        rem_q            <= '0;
                        quo_q            <= a_mag;
                        dsr_q            <= b_mag;
                        neg_q            <= a_neg ^ b_neg;
                        neg_r            <= a_neg;
                        bus.resp_divzero <= 1'b0;
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_chain[BITS_PER_CYCLE];
                    quo_q <= quo_chain[BITS_PER_CYCLE];
                    count <= count + 1'b1;
                    if (count == CNT_W'(N - 1)) begin
                        state           <= ST_DONE;
                        bus.resp_result <= rem_op_q ? r_fin : q_fin;
                    end
                end
                ST_DONE: if (bus.resp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Randomised and directed bench for div_unit: two instances (1 and 4 bits/cycle)
// share stimulus; results are predicted with plain integer arithmetic.
module tb_div_unit;
  import div_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [XLEN-1:0] MIN_VAL = 32'h8000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  // shared stimulus, routed to one instance by use4
  logic             use4;
  logic             req_valid;
  div_op_e          req_op;
  logic [XLEN-1:0]  req_dividend, req_divisor;
  logic [TAG_W-1:0] req_tag;
  logic             resp_ready;
  logic [1:0]       dbg1, dbg4;

  div_if #(.XLEN(XLEN), .TAG_W(TAG_W)) if1 ();
  div_if #(.XLEN(XLEN), .TAG_W(TAG_W)) if4 ();

  assign if1.req_valid    = req_valid && !use4;
  assign if4.req_valid    = req_valid && use4;
  assign if1.req_op       = req_op;
  assign if4.req_op       = req_op;
  assign if1.req_dividend = req_dividend;
  assign if4.req_dividend = req_dividend;
  assign if1.req_divisor  = req_divisor;
  assign if4.req_divisor  = req_divisor;
  assign if1.req_tag      = req_tag;
  assign if4.req_tag      = req_tag;
  assign if1.resp_ready   = resp_ready;
  assign if4.resp_ready   = resp_ready;

  div_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1), .TAG_W(TAG_W)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if1.slave), .dbg_state(dbg1));
  div_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(4), .TAG_W(TAG_W)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if4.slave), .dbg_state(dbg4));

  logic             obs_req_ready, obs_resp_valid, obs_divzero;
  logic [XLEN-1:0]  obs_result;
  logic [TAG_W-1:0] obs_tag;
  assign obs_req_ready  = use4 ? if4.req_ready    : if1.req_ready;
  assign obs_resp_valid = use4 ? if4.resp_valid   : if1.resp_valid;
  assign obs_result     = use4 ? if4.resp_result  : if1.resp_result;
  assign obs_divzero    = use4 ? if4.resp_divzero : if1.resp_divzero;
  assign obs_tag        = use4 ? if4.resp_tag     : if1.resp_tag;

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // reference model: RISC-V M semantics from plain integer arithmetic
  function automatic logic [XLEN-1:0] model_result(div_op_e op, logic [XLEN-1:0] a,
                                                   logic [XLEN-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) return (op == REM || op == REMU) ? a : '1;
    case (op)
      DIV:     return XLEN'(sa / sb);
      DIVU:    return a / b;
      REM:     return XLEN'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_latency(div_op_e op, logic [XLEN-1:0] a,
                                       logic [XLEN-1:0] b, int bpc);
    bit sgn;
    sgn = (op == DIV || op == REM);
    if (b == 0 || (sgn && a == MIN_VAL && b == '1)) return 1;
    return XLEN / bpc + 1;
  endfunction

  function automatic logic [XLEN-1:0] rand_operand();
    logic [XLEN-1:0] v;
    case ($urandom_range(0, 6))
      0: v = '0;
      1: v = '1;
      2: v = MIN_VAL;
      3: v = XLEN'($urandom_range(0, 20));
      4: begin v = XLEN'($urandom_range(1, 20)); v = -v; end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // driver: issue one request, measure latency, check response, hold, handshake
  task automatic run_op(input div_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] tag, input int hold);
    int lat, guard, exp_lat;
    logic [XLEN-1:0] exp_r;
    exp_q.push_back(model_result(op, a, b));
    exp_lat = model_latency(op, a, b, use4 ? 4 : 1);
    @(negedge clk);
    req_op = op; req_dividend = a; req_divisor = b; req_tag = tag; req_valid = 1'b1;
    #1;
    guard = 0;
    while (!obs_req_ready && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!obs_resp_valid && lat < 200);
    exp_r = exp_q.pop_front();
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", obs_result, exp_r);
    check("divzero", obs_divzero, b == 0);
    check("tag", obs_tag, tag);
    check("busy_ready", obs_req_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", obs_resp_valid, 1'b1);
      check("hold_result", obs_result, exp_r);
      check("hold_tag", obs_tag, tag);
      check("hold_ready", obs_req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("ready_after_hs", obs_req_ready, 1'b1);
    check("valid_after_hs", obs_resp_valid, 1'b0);
  endtask

  task automatic check_resp_zero(input string name);
    check({name, "_valid"}, {if4.resp_valid, if1.resp_valid}, 2'b00);
    check({name, "_result"}, {if4.resp_result, if1.resp_result}, 64'd0);
    check({name, "_divzero"}, {if4.resp_divzero, if1.resp_divzero}, 2'b00);
    check({name, "_tag"}, {if4.resp_tag, if1.resp_tag}, 10'd0);
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (obs_resp_valid) seen = 1'b1;
    end
    check(name, seen, 1'b0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    int wait_n;
    div_op_e op;
    reset = 1'b1; flush = 1'b0; use4 = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = DIV; req_dividend = '0; req_divisor = '0; req_tag = '0;
    repeat (2) @(negedge clk);
    check_resp_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {if4.req_ready, if1.req_ready}, 2'b11);

    // directed, 1 bit per cycle
    run_op(DIV,  32'hFFFF_FFF9, 32'd2, 5'd1, 0);
    run_op(REM,  32'hFFFF_FFF9, 32'd2, 5'd2, 0);
    run_op(DIVU, 32'h1234_5678, 32'd0, 5'd3, 0);
    run_op(REMU, 32'd13,        32'd0, 5'd4, 0);
    run_op(DIV,  MIN_VAL,       '1,    5'd5, 0);
    run_op(REM,  MIN_VAL,       '1,    5'd6, 0);
    run_op(DIVU, MIN_VAL,       '1,    5'd7, 0);
    run_op(REMU, 32'd100,       32'd7, 5'd9, 5);

    // flush during CALC iteration 10
    @(negedge clk);
    req_op = DIV; req_dividend = 32'd1000; req_divisor = 32'd3; req_tag = 5'd10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    repeat (11) begin @(negedge clk); if (obs_resp_valid) seen = 1'b1; end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_ready", obs_req_ready, 1'b1);
    watch_quiet("flush_no_resp", 40);
    check("flush_early_resp", seen, 1'b0);
    run_op(REM, 32'hFFFF_FC18, 32'd3, 5'd11, 0);

    // flush gates acceptance in IDLE
    @(negedge clk);
    req_op = DIV; req_dividend = 32'd50; req_divisor = 32'd5; req_valid = 1'b1; flush = 1'b1;
    #1 check("flush_gates_ready", obs_req_ready, 1'b0);
    @(posedge clk);
    #1 begin req_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("flush_no_accept", obs_req_ready, 1'b1);

    // flush beats a simultaneous resp_ready in DONE
    @(negedge clk);
    req_op = DIVU; req_dividend = 32'd9; req_divisor = 32'd0; req_tag = 5'd12; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("done_before_flush", obs_resp_valid, 1'b1);
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    #1 begin flush = 1'b0; resp_ready = 1'b0; end
    @(negedge clk);
    check("flush_done_valid", obs_resp_valid, 1'b0);
    check("flush_done_ready", obs_req_ready, 1'b1);

    // reset mid-CALC
    @(negedge clk);
    req_op = DIVU; req_dividend = 32'hDEAD_BEEF; req_divisor = 32'd77; req_tag = 5'd21; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1 check_resp_zero("rst_calc");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_calc_ready", obs_req_ready, 1'b1);
    watch_quiet("rst_calc_no_resp", 40);

    // 4 bits per cycle
    @(negedge clk);
    use4 = 1'b1;
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 5'd13, 0);
    run_op(REM, 32'hFFFF_FFF9, 32'd2, 5'd14, 1);

    // reset at a random point while DONE holds a result
    @(negedge clk);
    req_op = DIVU; req_dividend = 32'h1234_5678; req_divisor = 32'd0; req_tag = 5'd30; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_n = 0;
    do begin @(negedge clk); wait_n++; end while (!obs_resp_valid && wait_n < 50);
    check("rst_done_valid", obs_resp_valid, 1'b1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    #($urandom_range(1, 4));
    reset = 1'b1;
    #1 check_resp_zero("rst_done");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_done_ready", obs_req_ready, 1'b1);
    watch_quiet("rst_done_no_resp", 10);

    // random regression
    for (int i = 0; i < 2000; i++) begin
      op = div_op_e'($urandom_range(0, 3));
      run_op(op, rand_operand(), rand_operand(), TAG_W'($urandom), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
